// File: rtl/alu32_core_pkg.sv
// alu32_core_pkg: data width limit, opcode constants and decode helpers shared by the ALU files.
package alu32_core_pkg;
   localparam int DATA_INDEX_LIMIT = 31;
   typedef enum logic [4:0] {
      ALU_NOP = 5'd0,
      ALU_ADD = 5'd1,
      ALU_SUB = 5'd2,
      ALU_MUL = 5'd3,
      ALU_SRL = 5'd4,
      ALU_SLL = 5'd5,
      ALU_AND = 5'd6,
      ALU_OR  = 5'd7,
      ALU_NOR = 5'd8,
      ALU_SLT = 5'd9
   } alu_op_e;
   localparam int NUM_OPS = 9;

   // The adder subtracts for both SUB and SLT.
   function automatic logic op_subtracts(input logic [4:0] op);
      return (op == ALU_SUB) || (op == ALU_SLT);
   endfunction
endpackage

// File: rtl/alu32_core_if.sv
// alu32_core_if: operand, opcode and result bundle of the ALU.
interface alu32_core_if;
   import alu32_core_pkg::*;
   logic [DATA_INDEX_LIMIT:0] A;
   logic [DATA_INDEX_LIMIT:0] B;
   logic [5:0]                OPRN;
   logic [DATA_INDEX_LIMIT:0] Y;
   logic                      ZERO;
   logic [DATA_INDEX_LIMIT:0] Y_Q;
   logic                      ZERO_Q;
   modport master (output A, B, OPRN, input Y, ZERO, Y_Q, ZERO_Q);
   modport slave  (input A, B, OPRN, output Y, ZERO, Y_Q, ZERO_Q);
endinterface

// File: rtl/alu32_core_mux32_2x1.sv
// mux32_2x1: 32-bit two-way selector; S=0 passes I0, S=1 passes I1.
module mux32_2x1
   import alu32_core_pkg::*;
(
   output logic [DATA_INDEX_LIMIT:0] Y,
   input  logic [DATA_INDEX_LIMIT:0] I0,
   input  logic [DATA_INDEX_LIMIT:0] I1,
   input  logic                      S
);
   assign Y = S ? I1 : I0;
endmodule

// File: rtl/alu32_core_rc_add_sub_32.sv
// rc_add_sub_32: 32-bit ripple-carry adder/subtractor; SnA=1 computes A + ~B + 1.
module rc_add_sub_32
   import alu32_core_pkg::*;
(
   output logic [DATA_INDEX_LIMIT:0] Y,
   output logic                      CO,
   input  logic [DATA_INDEX_LIMIT:0] A,
   input  logic [DATA_INDEX_LIMIT:0] B,
   input  logic                      SnA
);
   logic [DATA_INDEX_LIMIT:0]   w_b;
   logic [DATA_INDEX_LIMIT+1:0] w_c;
   assign w_b    = B ^ {(DATA_INDEX_LIMIT+1){SnA}};
   assign w_c[0] = SnA;
   for (genvar i = 0; i <= DATA_INDEX_LIMIT; i++) begin : g_fa
      assign Y[i]     = A[i] ^ w_b[i] ^ w_c[i];
      assign w_c[i+1] = (A[i] & w_b[i]) | (w_c[i] & (A[i] ^ w_b[i]));
   end
   assign CO = w_c[DATA_INDEX_LIMIT+1];
endmodule

// File: rtl/alu32_core.sv
// alu32_core: 32-bit ALU with combinational Y/ZERO and a registered copy for debug/pipelining.
module alu32_core
   import alu32_core_pkg::*;
(
   input  logic         CLK,
   input  logic         RST,
   alu32_core_if.slave  bus
);
   logic [4:0]                w_op;
   logic [DATA_INDEX_LIMIT:0] w_sum;
   logic                      w_co;
   logic                      w_ov;
   logic                      w_slt;
   logic                      w_big;
   logic [DATA_INDEX_LIMIT:0] w_res   [1:NUM_OPS];
   logic [DATA_INDEX_LIMIT:0] w_chain [0:NUM_OPS];
   logic [DATA_INDEX_LIMIT:0] w_y;
   logic [DATA_INDEX_LIMIT:0] r_y_q;
   logic                      r_zero_q;

   // Masking keeps OPRN[5] out of the decode.
   assign w_op = 5'(bus.OPRN & 6'h1F);

   rc_add_sub_32 u_add_sub (
      .Y   (w_sum),
      .CO  (w_co),
      .A   (bus.A),
      .B   (bus.B),
      .SnA (op_subtracts(w_op))
   );

   // Overflow is carry-in XOR carry-out of the sign bit; B is inverted when subtracting.
   assign w_ov  = w_co ^ bus.A[DATA_INDEX_LIMIT] ^ ~bus.B[DATA_INDEX_LIMIT] ^ w_sum[DATA_INDEX_LIMIT];
   assign w_slt = w_sum[DATA_INDEX_LIMIT] ^ w_ov;
   assign w_big = |bus.B[DATA_INDEX_LIMIT:5];

   assign w_res[ALU_ADD] = w_sum;
   assign w_res[ALU_SUB] = w_sum;
   assign w_res[ALU_MUL] = bus.A * bus.B;
   assign w_res[ALU_SRL] = w_big ? '0 : bus.A >> bus.B[4:0];
   assign w_res[ALU_SLL] = w_big ? '0 : bus.A << bus.B[4:0];
   assign w_res[ALU_AND] = bus.A & bus.B;
   assign w_res[ALU_OR]  = bus.A | bus.B;
   assign w_res[ALU_NOR] = ~(bus.A | bus.B);
   assign w_res[ALU_SLT] = {{DATA_INDEX_LIMIT{1'b0}}, w_slt};

   // Unknown opcodes fall through every stage and leave zero.
   assign w_chain[0] = '0;
   for (genvar k = 1; k <= NUM_OPS; k++) begin : g_sel
      mux32_2x1 u_mux (
         .Y  (w_chain[k]),
         .I0 (w_chain[k-1]),
         .I1 (w_res[k]),
         .S  (w_op == 5'(k))
      );
   end
   assign w_y      = w_chain[NUM_OPS];
   assign bus.Y    = w_y;
   assign bus.ZERO = ~|w_y;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_y_q    <= '0;
         r_zero_q <= 1'b0;
      end else begin
         r_y_q    <= w_y;
         r_zero_q <= ~|w_y;
      end
   end
   assign bus.Y_Q    = r_y_q;
   assign bus.ZERO_Q = r_zero_q;
endmodule

// File: tb/tb_alu32_core.sv
// tb_alu32_core: directed vectors with hand-computed results for alu32_core.
module tb_alu32_core;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;

   alu32_core_if bus ();
   alu32_core dut (.CLK(clk), .RST(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [5:0] op, input logic [31:0] y, input logic z);
      bus.A = a;
      bus.B = b;
      bus.OPRN = op;
      #1;
      chk({tag, ".Y"}, bus.Y, y);
      chk({tag, ".ZERO"}, {31'd0, bus.ZERO}, {31'd0, z});
   endtask

   initial begin
      bus.A = '0;
      bus.B = '0;
      bus.OPRN = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.Y_Q", bus.Y_Q, 32'd0);
      chk("rst.ZERO_Q", {31'd0, bus.ZERO_Q}, 32'd0);
      vec("rst_track", 32'd3, 32'd4, 6'h01, 32'd7, 1'b0);
      chk("rst_hold.Y_Q", bus.Y_Q, 32'd0);

      @(negedge clk);
      rst = 1'b1;
      vec("add34", 32'd3, 32'd4, 6'h01, 32'd7, 1'b0);
      @(posedge clk);
      #1;
      chk("reg.Y_Q", bus.Y_Q, 32'd7);
      chk("reg.ZERO_Q", {31'd0, bus.ZERO_Q}, 32'd0);

      vec("add_ovf", 32'h7FFFFFFF, 32'd1, 6'h01, 32'h80000000, 1'b0);
      vec("add_wrap", 32'hFFFFFFFF, 32'd1, 6'h01, 32'd0, 1'b1);
      vec("sub_eq", 32'd5, 32'd5, 6'h02, 32'd0, 1'b1);
      vec("sub_neg", 32'd0, 32'd1, 6'h02, 32'hFFFFFFFF, 1'b0);
      vec("sub_big", 32'd100, 32'd58, 6'h02, 32'd42, 1'b0);
      vec("mul_wrap", 32'h00010000, 32'h00010000, 6'h03, 32'd0, 1'b1);
      vec("mul_76", 32'd7, 32'd6, 6'h03, 32'd42, 1'b0);
      vec("mul_neg", 32'hFFFFFFFF, 32'hFFFFFFFF, 6'h03, 32'd1, 1'b0);
      vec("srl31", 32'h80000000, 32'd31, 6'h04, 32'd1, 1'b0);
      vec("srl4", 32'hF0000000, 32'd4, 6'h04, 32'h0F000000, 1'b0);
      vec("srl32", 32'h80000000, 32'd32, 6'h04, 32'd0, 1'b1);
      vec("srl_hi", 32'hFFFFFFFF, 32'h00000101, 6'h04, 32'd0, 1'b1);
      vec("sll4", 32'd1, 32'd4, 6'h05, 32'd16, 1'b0);
      vec("sll32", 32'd1, 32'd32, 6'h05, 32'd0, 1'b1);
      vec("sll31", 32'd3, 32'd31, 6'h05, 32'h80000000, 1'b0);
      vec("and", 32'hF0F0F0F0, 32'h0FF00FF0, 6'h06, 32'h00F000F0, 1'b0);
      vec("or", 32'hF0F0F0F0, 32'h0FF00FF0, 6'h07, 32'hFFF0FFF0, 1'b0);
      vec("nor", 32'hF0F0F0F0, 32'h0FF00FF0, 6'h08, 32'h000F000F, 1'b0);
      vec("slt_ovf", 32'h80000000, 32'd1, 6'h09, 32'd1, 1'b0);
      vec("slt_ovf2", 32'h7FFFFFFF, 32'hFFFFFFFF, 6'h09, 32'd0, 1'b1);
      vec("slt_eq", 32'd9, 32'd9, 6'h09, 32'd0, 1'b1);
      vec("slt_neg", 32'hFFFFFFFE, 32'hFFFFFFFF, 6'h09, 32'd1, 1'b0);
      vec("slt_pos", 32'd2, 32'd1, 6'h09, 32'd0, 1'b1);
      vec("op21_add", 32'd10, 32'd20, 6'h21, 32'd30, 1'b0);
      vec("op22_sub", 32'd10, 32'd3, 6'h22, 32'd7, 1'b0);
      vec("op0a", 32'd10, 32'd20, 6'h0A, 32'd0, 1'b1);
      vec("op00", 32'd10, 32'd20, 6'h00, 32'd0, 1'b1);
      vec("op1f", 32'd10, 32'd20, 6'h1F, 32'd0, 1'b1);

      @(posedge clk);
      #1;
      chk("regz.Y_Q", bus.Y_Q, 32'd0);
      chk("regz.ZERO_Q", {31'd0, bus.ZERO_Q}, 32'd1);

      vec("add_pre", 32'd3, 32'd4, 6'h01, 32'd7, 1'b0);
      @(posedge clk);
      #1;
      chk("pre.Y_Q", bus.Y_Q, 32'd7);
      #2;
      rst = 1'b0;
      #1;
      chk("async.Y_Q", bus.Y_Q, 32'd0);
      chk("async.ZERO_Q", {31'd0, bus.ZERO_Q}, 32'd0);
      chk("async.Y", bus.Y, 32'd7);
      @(posedge clk);
      #1;
      chk("held.Y_Q", bus.Y_Q, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rel.Y_Q", bus.Y_Q, 32'd0);
      @(posedge clk);
      #1;
      chk("rel_edge.Y_Q", bus.Y_Q, 32'd7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
